dcache_ctrl: RTL and testbench

Sequencing controller for the 2-way set-associative data cache. It turns core load/store and fence requests plus cache status into the cache's per-cycle control strobes. It sequences dirty-victim writeback, block refill and full-cache fence writeback over the AXI burst interface, and stalls the core until each request completes. It sits between the core memory stage, the data cache and the AXI master.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_ctrl.sv | 134 +++++++++++++
 tb/tb_dcache_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and sizing for the data cache controller.
// FENCE_BLOCKS_DEF also sizes the data cache walk counter.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    FENCE_CHECK,
    FENCE_WB
  } t_dcache_state;

  localparam int FENCE_BLOCKS_DEF = 4;

endpackage

// File: rtl/dcache_ctrl.sv
// Data cache sequencing FSM: hits, dirty writeback, refill
// and full-cache fence walk over the AXI burst interface.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int FENCE_BLOCKS = FENCE_BLOCKS_DEF
) (
  input  logic clk,
  input  logic arst,
  input  logic i_mem_req,
  input  logic i_mem_we,
  input  logic i_fence,
  input  logic i_hit,
  input  logic i_dirty,
  input  logic i_axi_done,
  output logic o_stall,
  output logic o_write_en,
  output logic o_valid_update,
  output logic o_lru_update,
  output logic o_block_write_en,
  output logic o_addr_control,
  output logic o_start_wb,
  output logic o_done_wb,
  output logic o_axi_rd_start,
  output logic o_axi_wr_start,
  output logic o_fence_done
);

  localparam int FW =
    (FENCE_BLOCKS > 1) ? $clog2(FENCE_BLOCKS) : 1;
  localparam logic [FW-1:0] LAST =
    FW'(FENCE_BLOCKS - 1);

  t_dcache_state state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          blk_done;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    fcnt_nxt         = fcnt;
    blk_done         = 1'b0;
    o_stall          = 1'b0;
    o_write_en       = 1'b0;
    o_valid_update   = 1'b0;
    o_lru_update     = 1'b0;
    o_block_write_en = 1'b0;
    o_addr_control   = 1'b0;
    o_start_wb       = 1'b0;
    o_done_wb        = 1'b0;
    o_axi_rd_start   = 1'b0;
    o_axi_wr_start   = 1'b0;
    o_fence_done     = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_fence) begin
          o_stall   = 1'b1;
          state_nxt = FENCE_CHECK;
        end else if (i_mem_req) begin
          if (i_hit) begin
            o_lru_update = 1'b1;
            o_write_en   = i_mem_we;
          end else if (i_dirty) begin
            o_stall        = 1'b1;
            o_axi_wr_start = 1'b1;
            state_nxt      = WRITEBACK;
          end else begin
            o_stall        = 1'b1;
            o_axi_rd_start = 1'b1;
            o_addr_control = 1'b1;
            state_nxt      = REFILL;
          end
        end
      end
      WRITEBACK: begin
        o_stall = 1'b1;
        // the read burst launched here targets the request address
        if (i_axi_done) begin
          o_axi_rd_start = 1'b1;
          o_addr_control = 1'b1;
          state_nxt      = REFILL;
        end
      end
      REFILL: begin
        o_stall        = 1'b1;
        o_addr_control = 1'b1;
        if (i_axi_done) begin
          o_block_write_en = 1'b1;
          o_valid_update   = 1'b1;
          state_nxt        = IDLE;
        end
      end
      FENCE_CHECK: begin
        o_stall    = 1'b1;
        o_start_wb = 1'b1;
        if (i_dirty) begin
          o_axi_wr_start = 1'b1;
          state_nxt      = FENCE_WB;
        end else begin
          blk_done = 1'b1;
        end
      end
      FENCE_WB: begin
        o_stall    = 1'b1;
        o_start_wb = 1'b1;
        blk_done   = i_axi_done;
      end
      default: state_nxt = IDLE;
    endcase

    if (blk_done) begin
      o_done_wb = 1'b1;
      if (fcnt == LAST) begin
        o_fence_done = 1'b1;
        fcnt_nxt     = '0;
        state_nxt    = IDLE;
      end else begin
        fcnt_nxt  = fcnt + 1'b1;
        state_nxt = FENCE_CHECK;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, misses, fences, reset.
// Outputs are sampled mid-cycle after inputs settle.
module tb_dcache_ctrl;

  logic clk, arst;
  logic req, we, fence, hit, dirty, done;
  logic stall, wen, vu, lu, bwe, ac, swb, dwb, rds, wrs, fd;
  logic [10:0] obs;

  localparam logic [10:0] S  = 11'b10000000000;
  localparam logic [10:0] WE = 11'b01000000000;
  localparam logic [10:0] VU = 11'b00100000000;
  localparam logic [10:0] LU = 11'b00010000000;
  localparam logic [10:0] BW = 11'b00001000000;
  localparam logic [10:0] AC = 11'b00000100000;
  localparam logic [10:0] SW = 11'b00000010000;
  localparam logic [10:0] DW = 11'b00000001000;
  localparam logic [10:0] RD = 11'b00000000100;
  localparam logic [10:0] WR = 11'b00000000010;
  localparam logic [10:0] FD = 11'b00000000001;
  localparam logic [10:0] Z  = 11'b00000000000;

  int total = 0;
  int passed = 0;

  dcache_ctrl #(.FENCE_BLOCKS(4)) dut (
    .clk(clk), .arst(arst),
    .i_mem_req(req), .i_mem_we(we), .i_fence(fence),
    .i_hit(hit), .i_dirty(dirty), .i_axi_done(done),
    .o_stall(stall), .o_write_en(wen),
    .o_valid_update(vu), .o_lru_update(lu),
    .o_block_write_en(bwe), .o_addr_control(ac),
    .o_start_wb(swb), .o_done_wb(dwb),
    .o_axi_rd_start(rds), .o_axi_wr_start(wrs),
    .o_fence_done(fd)
  );

  assign obs = {stall, wen, vu, lu, bwe, ac,
                swb, dwb, rds, wrs, fd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic r, input logic w,
                     input logic f, input logic h,
                     input logic d, input logic a);
    req = r; we = w; fence = f;
    hit = h; dirty = d; done = a;
  endtask

  task automatic chk(input string tag,
                     input logic [10:0] exp);
    #2;
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b",
                tag, obs, exp);
  endtask

  initial begin
    arst = 1'b1;
    set(0, 0, 0, 0, 0, 0);
    #10;
    chk("reset", Z);
    tick();
    arst = 1'b0;
    chk("post_reset", Z);

    // store hit / load hit
    tick(); set(1, 1, 0, 1, 0, 0); chk("store_hit", WE | LU);
    tick(); set(1, 0, 0, 1, 0, 0); chk("load_hit", LU);

    // clean miss, read latency 5
    tick(); set(1, 0, 0, 0, 0, 0); chk("cm_start", S | AC | RD);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("cm_wait", S | AC);
    end
    tick(); done = 1; chk("cm_fill", S | AC | BW | VU);
    tick(); set(1, 0, 0, 1, 0, 0); chk("cm_replay", LU);
    tick(); set(0, 0, 0, 0, 0, 1); chk("idle_done_ign", Z);

    // dirty miss
    tick(); set(1, 1, 0, 0, 1, 0); chk("dm_wr_start", S | WR);
    tick(); dirty = 0; chk("dm_wb_wait", S);
    tick(); chk("dm_wb_wait2", S);
    tick(); done = 1; chk("dm_rd_start", S | AC | RD);
    tick(); done = 0; chk("dm_refill", S | AC);
    tick(); done = 1; chk("dm_fill", S | AC | BW | VU);
    tick(); set(1, 1, 0, 1, 0, 0); chk("dm_replay", WE | LU);
    tick(); set(0, 0, 0, 0, 0, 0); chk("dm_idle", Z);

    // fence, all clean
    tick(); set(0, 0, 1, 0, 0, 0); chk("fc_enter", S);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("fc_block", S | SW | DW);
    end
    tick(); chk("fc_last", S | SW | DW | FD);
    tick(); fence = 0; chk("fc_idle", Z);

    // fence, block 2 dirty
    tick(); set(0, 0, 1, 0, 0, 0); chk("fd_enter", S);
    tick(); chk("fd_blk0", S | SW | DW);
    tick(); chk("fd_blk1", S | SW | DW);
    tick(); dirty = 1; chk("fd_blk2_wr", S | SW | WR);
    tick(); dirty = 0; chk("fd_wb_wait", S | SW);
    tick(); done = 1; chk("fd_wb_done", S | SW | DW);
    tick(); done = 0; chk("fd_blk3", S | SW | DW | FD);
    tick(); fence = 0; chk("fd_idle", Z);

    // reset during refill
    tick(); set(1, 0, 0, 0, 0, 0); chk("rr_start", S | AC | RD);
    tick(); chk("rr_refill", S | AC);
    #1;
    arst = 1'b1;
    set(0, 0, 0, 0, 0, 1);
    chk("rr_in_reset", Z);
    tick(); chk("rr_held", Z);
    arst = 1'b0;
    done = 0;
    chk("rr_released", Z);

    // fence and request together
    tick(); set(1, 1, 1, 1, 0, 0); chk("fr_enter", S);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("fr_block", S | SW | DW);
    end
    tick(); chk("fr_last", S | SW | DW | FD);
    tick(); fence = 0; chk("fr_req_served", WE | LU);
    tick(); set(0, 0, 0, 0, 0, 0); chk("fr_idle", Z);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
